// File: rtl/spu_pkg.sv
// Shared definitions for the SPU loader/softmax/layernorm tops.
package spu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } spu_state_e;

  localparam int LANES = 4;
  localparam logic signed [7:0] INT8_MAX = 8'sd127;
  localparam logic signed [7:0] INT8_MIN = -8'sd128;

endpackage

// File: rtl/spu_sm_ld_if.sv
// Accumulator stream input and gbuf write port of the softmax loader.
interface spu_sm_ld_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 16
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [spu_pkg::LANES*ACC_WIDTH-1:0]  in_data;
  logic                                 ld_gbuf_wen;
  logic [ADDR_WIDTH-1:0]                ld_gbuf_waddr;
  logic [DATA_WIDTH-1:0]                ld_gbuf_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, ld_gbuf_wen, ld_gbuf_waddr, ld_gbuf_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, ld_gbuf_wen, ld_gbuf_waddr, ld_gbuf_wdata
  );
endinterface

// File: rtl/spu_requant_lane.sv
// One accumulator lane: round-half-up, arithmetic right shift, saturate to int8.
module spu_requant_lane
  import spu_pkg::*;
#(
  parameter int ACC_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  input  logic        [3:0]           shift_i,
  output logic signed [7:0]           q_o
);

  localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'(INT8_MAX);
  localparam logic signed [ACC_WIDTH:0] SAT_LO = (ACC_WIDTH+1)'(INT8_MIN);
  localparam logic        [ACC_WIDTH:0] ONE_W  = (ACC_WIDTH+1)'(1);

  logic signed [ACC_WIDTH:0] ext_s;
  logic signed [ACC_WIDTH:0] rnd_s;
  logic signed [ACC_WIDTH:0] sum_s;
  logic signed [ACC_WIDTH:0] shr_s;

  // One extra bit keeps the rounding add from overflowing.
  always_comb begin
    ext_s = {acc_i[ACC_WIDTH-1], acc_i};
    if (shift_i != 4'd0) begin
      rnd_s = ONE_W << (shift_i - 4'd1);
    end else begin
      rnd_s = '0;
    end
    sum_s = ext_s + rnd_s;
    shr_s = sum_s >>> shift_i;
    if (shr_s > SAT_HI) begin
      q_o = INT8_MAX;
    end else if (shr_s < SAT_LO) begin
      q_o = INT8_MIN;
    end else begin
      q_o = shr_s[7:0];
    end
  end

endmodule

// File: rtl/spu_sm_ld.sv
// Softmax loader: requantises the QK^T accumulator stream to int8 and writes it row by row into gbuf.
module spu_sm_ld
  import spu_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                  core_clk,
  input  logic                  rst,
  input  logic                  ld_start,
  output logic                  ld_end,
  input  logic [ADDR_WIDTH-1:0] spu_matrix_y,
  input  logic [ADDR_WIDTH-1:0] spu_matrix_x,
  input  logic [ADDR_WIDTH-1:0] om_base_addr,
  input  logic [ADDR_WIDTH-1:0] ofm_addr_align,
  input  logic [3:0]            ld_shift,
  spu_sm_ld_if.slave            bus
);

  localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_A = ADDR_WIDTH'(0);

  spu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] y_q, y_d, wpr_q, wpr_d, align_q, align_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d, col_q, col_d, row_base_q, row_base_d;
  logic [3:0]            shift_q, shift_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [LANES-1:0][7:0] lane_s;
  logic                  accept_s;
  logic                  row_end_s;
  logic                  last_s;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    spu_requant_lane #(.ACC_WIDTH(ACC_WIDTH)) u_lane (
      .acc_i   (bus.in_data[i*ACC_WIDTH +: ACC_WIDTH]),
      .shift_i (shift_q),
      .q_o     (lane_s[i])
    );
  end

  assign bus.in_ready      = (state_q == RUN);
  assign ld_end            = (state_q == DONE);
  assign bus.ld_gbuf_wen   = wen_q;
  assign bus.ld_gbuf_waddr = waddr_q;
  assign bus.ld_gbuf_wdata = wdata_q;

  // Next state, config capture, row/column walk and the write stage.
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    wpr_d      = wpr_q;
    align_d    = align_q;
    shift_d    = shift_q;
    row_d      = row_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    accept_s   = (state_q == RUN) && bus.in_valid;
    row_end_s  = (col_q == wpr_q - ONE_A);
    last_s     = row_end_s && (row_q == y_q - ONE_A);

    case (state_q)
      IDLE: begin
        if (ld_start) begin
          y_d        = spu_matrix_y;
          wpr_d      = spu_matrix_x >> 2;
          align_d    = ofm_addr_align;
          shift_d    = ld_shift;
          row_d      = ZERO_A;
          col_d      = ZERO_A;
          row_base_d = om_base_addr;
          if ((spu_matrix_y == ZERO_A) || ((spu_matrix_x >> 2) == ZERO_A)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s) begin
          wen_d   = 1'b1;
          waddr_d = row_base_q + col_q;
          wdata_d = DATA_WIDTH'(lane_s);
          if (row_end_s) begin
            col_d      = ZERO_A;
            row_d      = row_q + ONE_A;
            row_base_d = row_base_q + align_q;
          end else begin
            col_d = col_q + ONE_A;
          end
          if (last_s) begin
            state_d = FLUSH;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any load in flight.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      y_q        <= '0;
      wpr_q      <= '0;
      align_q    <= '0;
      shift_q    <= 4'd0;
      row_q      <= '0;
      col_q      <= '0;
      row_base_q <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      wpr_q      <= wpr_d;
      align_q    <= align_d;
      shift_q    <= shift_d;
      row_q      <= row_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_spu_sm_ld.sv
// Randomised scoreboard bench for spu_sm_ld against a behavioural loader model.
module tb_spu_sm_ld;
  import spu_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int ACCW = 16;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          core_clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_start = 1'b0;
  logic          ld_end;
  logic [AW-1:0] y_i = '0, x_i = '0, base_i = '0, align_i = '0;
  logic [3:0]    sh_i = 4'd0;

  spu_sm_ld_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(ACCW)) bus ();

  spu_sm_ld #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(ACCW)) dut (
    .core_clk       (core_clk),
    .rst            (rst),
    .ld_start       (ld_start),
    .ld_end         (ld_end),
    .spu_matrix_y   (y_i),
    .spu_matrix_x   (x_i),
    .om_base_addr   (base_i),
    .ofm_addr_align (align_i),
    .ld_shift       (sh_i),
    .bus            (bus)
  );

  wr_t         wq[$];
  int          end_q[$];        // -1: after last write, else the cycle the pulse must appear in
  logic [31:0] exp_fix[$];
  logic [63:0] data_src[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  initial forever #5 core_clk = ~core_clk;
  initial forever begin @(posedge core_clk); cyc++; end
  initial begin #3000000; $display("FAIL watchdog: simulation did not end, required finish"); $fatal(1); end

  // Reference requantisation, floor-division formulation.
  function automatic logic [31:0] model(input logic [63:0] w, input int sh);
    logic [31:0] r;
    int a, v;
    for (int i = 0; i < 4; i++) begin
      a = int'($signed(w[16*i +: 16]));
      if (sh > 0) v = (a + (1 << (sh - 1))) >>> sh;
      else        v = a;
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      r[8*i +: 8] = v[7:0];
    end
    return r;
  endfunction

  // Monitor / scoreboard
  initial begin
    logic acc_prev, last_prev;
    wr_t  e;
    int   tok;
    acc_prev = 1'b0;
    last_prev = 1'b0;
    forever begin
      @(negedge core_clk);
      if (rst) begin
        checks++;
        if (bus.ld_gbuf_wen !== 1'b0 || bus.in_ready !== 1'b0 || ld_end !== 1'b0 ||
            bus.ld_gbuf_waddr !== 12'h000 || bus.ld_gbuf_wdata !== 32'h0) begin
          errors++;
          $display("FAIL reset_outputs: wen=%0b ready=%0b end=%0b waddr=%h wdata=%h, required all zero",
                   bus.ld_gbuf_wen, bus.in_ready, ld_end, bus.ld_gbuf_waddr, bus.ld_gbuf_wdata);
        end
        acc_prev = 1'b0;
        last_prev = 1'b0;
      end else begin
        checks++;
        if (bus.ld_gbuf_wen !== acc_prev) begin
          errors++;
          $display("FAIL wen_latency: wen=%0b, required %0b (cycle %0d)", bus.ld_gbuf_wen, acc_prev, cyc);
        end
        if (bus.ld_gbuf_wen === 1'b1) begin
          if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: waddr=%h wdata=%h, required no write", bus.ld_gbuf_waddr, bus.ld_gbuf_wdata);
          end else begin
            e = wq.pop_front();
            checks++;
            if (bus.ld_gbuf_waddr !== e.a) begin
              errors++;
              $display("FAIL waddr: got %h, required %h", bus.ld_gbuf_waddr, e.a);
            end
            checks++;
            if (bus.ld_gbuf_wdata !== e.d) begin
              errors++;
              $display("FAIL wdata: got %h, required %h (addr %h)", bus.ld_gbuf_wdata, e.d, e.a);
            end
          end
        end
        if (ld_end === 1'b1) begin
          checks++;
          if (end_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ld_end: ld_end=1 at cycle %0d, required 0", cyc);
          end else begin
            tok = end_q.pop_front();
            if (tok < 0 && !last_prev) begin
              errors++;
              $display("FAIL ld_end_timing: got pulse not following final write, required 1 cycle after it");
            end else if (tok >= 0 && cyc != tok) begin
              errors++;
              $display("FAIL ld_end_degenerate: got cycle %0d, required %0d", cyc, tok);
            end
          end
        end
        last_prev = bus.ld_gbuf_wen && (wq.size() == 0);
        acc_prev = bus.in_valid && bus.in_ready;
      end
    end
  end

  // pat: 0 = valid held high, 1 = toggling, 2 = random
  task automatic load(input int y, input int x, input int base, input int align, input int sh,
                      input int pat, input int rst_after, input bit midstart);
    int wpr, total, k, it;
    bit abort, mid_done;
    logic [63:0] w;
    wr_t e;
    wpr = x >> 2;
    total = y * wpr;
    @(posedge core_clk); #1;
    y_i = 12'(y); x_i = 12'(x); base_i = 12'(base); align_i = 12'(align); sh_i = 4'(sh);
    ld_start = 1'b1;
    @(posedge core_clk); #1;
    ld_start = 1'b0;
    if (total == 0) end_q.push_back(cyc);
    k = 0; it = 0; abort = 1'b0; mid_done = 1'b0;
    while (k < total && !abort) begin
      ld_start = 1'b0;
      if (it >= 400) begin
        checks++; errors++;
        $display("FAIL accept_stall: got %0d accepts, required %0d", k, total);
        abort = 1'b1;
      end else begin
        if (pat == 0)      bus.in_valid = 1'b1;
        else if (pat == 1) bus.in_valid = (it % 2 == 0);
        else               bus.in_valid = 1'($urandom_range(0, 1));
        w = (data_src.size() != 0) ? data_src[0] : {$urandom, $urandom};
        bus.in_data = w;
        @(negedge core_clk);
        if (bus.in_valid && bus.in_ready) begin
          e.a = 12'(base + (k / wpr) * align + (k % wpr));
          e.d = (exp_fix.size() != 0) ? exp_fix.pop_front() : model(w, sh);
          wq.push_back(e);
          if (data_src.size() != 0) void'(data_src.pop_front());
          k++;
          if (k == total) end_q.push_back(-1);
        end
        @(posedge core_clk); #1;
        it++;
        if (midstart && !mid_done && k == 1) begin
          mid_done = 1'b1;
          ld_start = 1'b1;
          y_i = 12'h000; x_i = 12'h7FC; base_i = 12'hABC; align_i = 12'h555; sh_i = 4'd9;
        end
        if (rst_after >= 0 && k == rst_after) begin
          rst = 1'b1;
          abort = 1'b1;
        end
      end
    end
    ld_start = 1'b0;
    if (rst) begin
      bus.in_valid = 1'b0;
      wq.delete(); end_q.delete(); exp_fix.delete(); data_src.delete();
      repeat (2) @(posedge core_clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge core_clk);
    end else begin
      bus.in_valid = 1'b1;
      repeat (4) begin
        @(negedge core_clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_after_load: in_ready=%0b, required 0", bus.in_ready);
        end
        @(posedge core_clk); #1;
      end
      bus.in_valid = 1'b0;
      it = 0;
      while (end_q.size() != 0 && it < 50) begin @(posedge core_clk); it++; end
      checks++;
      if (end_q.size() != 0) begin
        errors++;
        $display("FAIL ld_end_missing: got %0d pulses outstanding, required 0", end_q.size());
      end
      checks++;
      if (wq.size() != 0) begin
        errors++;
        $display("FAIL writes_missing: got %0d writes outstanding, required 0", wq.size());
      end
      end_q.delete(); wq.delete();
      #1;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    repeat (3) @(posedge core_clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge core_clk);

    load(2, 8, 'h100, 'h10, 0, 0, -1, 1'b0);
    data_src.push_back(64'hFFFF_007F_FED4_012C);
    exp_fix.push_back(32'hFF7F807F);
    load(1, 4, 'h020, 'h4, 0, 0, -1, 1'b0);
    data_src.push_back(64'hFFFB_0005_FFFA_0006);
    exp_fix.push_back(32'hFE03FD03);
    load(1, 4, 'h030, 'h4, 1, 0, -1, 1'b0);
    load(2, 12, 'h200, 'h20, 2, 1, -1, 1'b0);
    load(0, 8, 'h040, 'h4, 0, 0, -1, 1'b0);
    load(3, 3, 'h040, 'h4, 0, 0, -1, 1'b0);
    load(2, 8, 'h300, 'h40, 3, 0, -1, 1'b1);
    load(3, 8, 'h050, 'h8, 0, 0, 2, 1'b0);
    load(1, 8, 'h050, 'h8, 4, 0, -1, 1'b0);
    load(1, 16, 'hFFE, 'h1, 0, 0, -1, 1'b0);
    for (int n = 0; n < 8; n++) begin
      load($urandom_range(1, 3), $urandom_range(4, 20), $urandom_range(0, 4095),
           $urandom_range(0, 4095), $urandom_range(0, 15), $urandom_range(0, 2), -1, 1'b0);
    end

    repeat (5) @(posedge core_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
